// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIXUP,
        ST_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               qbit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        qbit     = 1'b0;
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        if (mode) begin
            // Remainder stays below the divisor, so diff bit WIDTH is a clean borrow flag.
            qbit     = ~diff[WIDTH];
            acc_next = {(qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_t          state, state_nx;
    muldiv_op_t         op_r;
    logic [WIDTH-1:0]   a_r, b_r, opnd_r;
    logic [2*WIDTH-1:0] acc_r, step_acc;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_lo_r, neg_hi_r, dbz_r;
    logic               step_q, accept, op_div, op_signed, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    assign busy        = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIXUP);
    assign done        = (state == ST_DONE);
    assign div_by_zero = done & dbz_r;
    // A flush cancels the instruction that is raising start in the same cycle.
    assign accept      = start & ~busy & ~abort;

    assign op_div    = (op_r == MD_DIV) || (op_r == MD_DIVU);
    assign op_signed = (op_r == MD_MULT) || (op_r == MD_DIV);
    assign b_zero    = (b_r == '0);
    assign a_mag     = neg_if(op_signed & a_r[WIDTH-1], a_r);
    assign b_mag     = neg_if(op_signed & b_r[WIDTH-1], b_r);
    assign prod_fix  = neg_lo_r ? -acc_r : acc_r;
    assign q_fix     = neg_if(neg_lo_r, acc_r[WIDTH-1:0]);
    assign r_fix     = neg_if(neg_hi_r, acc_r[2*WIDTH-1:WIDTH]);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (op_div),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (step_acc),
        .qbit     (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_PREP;
            ST_PREP: begin
                if (abort)                 state_nx = ST_IDLE;
                else if (op_div && b_zero) state_nx = ST_DONE;
                else                       state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                  state_nx = ST_IDLE;
                else if (cnt_r == CNT_LAST) state_nx = ST_FIXUP;
            end
            ST_FIXUP: state_nx = abort ? ST_IDLE : ST_DONE;
            ST_DONE:  state_nx = accept ? ST_PREP : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= MD_MULT;
            a_r      <= '0;
            b_r      <= '0;
            opnd_r   <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            dbz_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (accept) begin
                op_r <= muldiv_op_t'(op);
                a_r  <= a;
                b_r  <= b;
            end
            if (!busy && !accept) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (busy && !abort) begin
                case (state)
                    ST_PREP: begin
                        cnt_r    <= '0;
                        neg_lo_r <= op_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                        neg_hi_r <= op_signed & (op_div ? a_r[WIDTH-1]
                                                        : (a_r[WIDTH-1] ^ b_r[WIDTH-1]));
                        dbz_r    <= op_div & b_zero;
                        if (op_div) begin
                            acc_r  <= {{WIDTH{1'b0}}, a_mag};
                            opnd_r <= b_mag;
                        end else begin
                            acc_r  <= {{WIDTH{1'b0}}, b_mag};
                            opnd_r <= a_mag;
                        end
                        if (op_div && b_zero) begin
                            hi <= a_r;
                            lo <= '1;
                        end
                    end
                    ST_RUN: begin
                        acc_r <= op_div ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
                        cnt_r <= cnt_r + 1'b1;
                    end
                    ST_FIXUP: begin
                        if (op_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
